// File: rtl/stmt_while_seq_accum.sv
// Sequential while-loop accumulator: one iteration per clock, valid/ready in and out.
// Define STMT_WHILE_SAT_EN to saturate the sum on overflow instead of wrapping.
module stmt_while_seq_accum #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_start_idx,
  input  logic [CNT_W-1:0]  in_limit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_limit;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sum;
  logic              r_ovf;

  logic              w_accept;
  logic              w_step;
  logic              w_cnt_done;
  logic              w_ovf;
  logic [DATA_W+1:0] w_term;
  logic [DATA_W-1:0] w_sum_nxt;

  // Two extra bits hold sum + data + idx without loss.
  always_comb begin
    w_term = {2'b00, r_sum} + {2'b00, r_data}
           + {{(DATA_W+2-IDX_W){1'b0}}, r_idx};
    w_ovf  = |w_term[DATA_W+1:DATA_W];
`ifdef STMT_WHILE_SAT_EN
    w_sum_nxt = w_ovf ? {DATA_W{1'b1}} : w_term[DATA_W-1:0];
`else
    w_sum_nxt = w_term[DATA_W-1:0];
`endif
  end

  assign w_cnt_done = (r_cnt == r_limit);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_cnt_done) begin
          w_state_nxt = S_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_idx   <= '0;
      r_limit <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data  <= in_data;
        r_idx   <= in_start_idx;
        r_limit <= in_limit;
        r_cnt   <= '0;
        r_sum   <= '0;
        r_ovf   <= 1'b0;
      end else if (w_step) begin
        r_sum <= w_sum_nxt;
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= r_ovf | w_ovf;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign out_sum   = r_sum;
  assign out_index = r_idx;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_stmt_while_seq_accum.sv
// Bench for stmt_while_seq_accum: vector table, corner sequences, random jobs vs model.
// Honours STMT_WHILE_SAT_EN for the expected overflow behaviour.
module tb_stmt_while_seq_accum;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 4;

`ifdef STMT_WHILE_SAT_EN
  localparam bit SAT     = 1'b1;
  localparam int OVF_SUM = 255;
`else
  localparam bit SAT     = 1'b0;
  localparam int OVF_SUM = 145;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_start_idx;
  logic [CNT_W-1:0]  in_limit;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic [IDX_W-1:0]  out_index;
  logic              out_ovf;
  logic              busy;

  stmt_while_seq_accum #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_start_idx(in_start_idx),
    .in_limit    (in_limit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_index   (out_index),
    .out_ovf     (out_ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int data;
    int start;
    int limit;
    int sum;
    int idx;
    int ovf;
    int lat;
  } vec_t;

  // Reference: run the loop straight from the arithmetic rules.
  task automatic model(input int d, input int s, input int l,
                       output int sum, output int idx, output int ovf);
    int t;
    sum = 0;
    idx = s;
    ovf = 0;
    for (int i = 0; i < l; i++) begin
      t = sum + d + idx;
      if (t >= 256) begin
        ovf = 1;
        sum = SAT ? 255 : t % 256;
      end else begin
        sum = t;
      end
      idx = (idx + 1) % 16;
    end
  endtask

  // Offers a job, waits for out_valid (bounded); leaves the block in DONE.
  task automatic launch(input int d, input int s, input int l,
                        output int lat);
    @(negedge clk);
    in_data      = DATA_W'(d);
    in_start_idx = IDX_W'(s);
    in_limit     = CNT_W'(l);
    in_valid     = 1'b1;
    @(posedge clk);
    #1 in_valid  = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    if (!out_valid) $display("FAIL timeout: out_valid got 0 expected 1");
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  vec_t vecs[5];
  int   lat;
  int   m_sum, m_idx, m_ovf;
  int   h_sum, h_idx, h_ovf;
  int   d, s, l;

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_start_idx = '0;
    in_limit     = '0;
    out_ready    = 1'b0;

    vecs[0] = '{3,   2,  5, 35,      7,  0, 6};
    vecs[1] = '{9,   6,  0, 0,       6,  0, 1};
    vecs[2] = '{0,   14, 5, 32,      3,  0, 6};
    vecs[3] = '{200, 0,  2, OVF_SUM, 2,  1, 3};
    vecs[4] = '{1,   0,  15, 120,    15, 0, 16};

    #12;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst out_sum", int'(out_sum), 0);
    chk("rst out_index", int'(out_index), 0);
    chk("rst out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].data, vecs[i].start, vecs[i].limit, lat);
      chk($sformatf("vec%0d sum", i), int'(out_sum), vecs[i].sum);
      chk($sformatf("vec%0d idx", i), int'(out_index), vecs[i].idx);
      chk($sformatf("vec%0d ovf", i), int'(out_ovf), vecs[i].ovf);
      chk($sformatf("vec%0d lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d in_ready", i), int'(in_ready), 0);
      drain();
      chk($sformatf("vec%0d idle", i), int'(in_ready), 1);
    end

    // Backpressure in DONE while new jobs are waved at the input.
    launch(3, 2, 5, lat);
    h_sum = int'(out_sum);
    h_idx = int'(out_index);
    h_ovf = int'(out_ovf);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid     = ~in_valid;
      in_data      = DATA_W'($urandom);
      in_start_idx = IDX_W'($urandom);
      in_limit     = CNT_W'($urandom);
      @(posedge clk);
      #1;
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp sum", int'(out_sum), h_sum);
      chk("bp idx", int'(out_index), h_idx);
      chk("bp ovf", int'(out_ovf), h_ovf);
    end
    in_valid = 1'b0;
    chk("bp held sum", h_sum, 35);
    chk("bp held idx", h_idx, 7);
    drain();

    // Reset after two of five iterations.
    @(negedge clk);
    in_data      = 8'd3;
    in_start_idx = 4'd2;
    in_limit     = 4'd5;
    in_valid     = 1'b1;
    @(posedge clk);
    #1 in_valid  = 1'b0;
    chk("mid busy", int'(busy), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort in_ready", int'(in_ready), 1);
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort sum", int'(out_sum), 0);
    chk("abort idx", int'(out_index), 0);
    chk("abort ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    launch(3, 2, 5, lat);
    chk("post sum", int'(out_sum), 35);
    chk("post idx", int'(out_index), 7);
    chk("post lat", lat, 6);
    drain();

    for (int k = 0; k < 40; k++) begin
      d = int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 15));
      model(d, s, l, m_sum, m_idx, m_ovf);
      launch(d, s, l, lat);
      chk("rnd sum", int'(out_sum), m_sum);
      chk("rnd idx", int'(out_index), m_idx);
      chk("rnd ovf", int'(out_ovf), m_ovf);
      chk("rnd lat", lat, l + 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
